sample_framer: RTL and testbench

//  Upstream stage of the output counter in the log-mel front end. It buffers the

---
 rtl/sample_framer.sv | 135 +++++++++++++
 tb/tb_sample_framer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// Purpose: buffers an audio sample stream and replays it as overlapping frames
//          (FRAME_LEN samples, stride HOP), one sample per cycle.
// Latency: first do_en one cycle after EMIT is entered (registered buffer read);
//          each frame is a gap-free burst of FRAME_LEN cycles.
// Backpressure: di_rdy is low outside FILL/HOP. Offers while not ready are dropped,
//          and ovf latches if the drop happens during EMIT. There is no output
//          backpressure.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   start             one-cycle pulse, starts a run from IDLE or DONE
//   di_en/data_i      input sample stream, accepted when di_en && di_rdy
//   di_rdy            framer accepts a sample this cycle
//   do_en/data_o      output sample stream
//   frame_idx         0-based index of the frame currently on data_o
//   frame_last        marks the last sample of each frame
//   done              all NUM_FRAMES frames emitted
//   ovf               sticky, set when an input was offered during EMIT
module sample_framer #(
  parameter int I_BW       = 14,
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128,
  parameter int NUM_FRAMES = 59,
  localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            di_en,
  input  logic [I_BW-1:0] data_i,
  output logic            di_rdy,
  output logic            do_en,
  output logic [I_BW-1:0] data_o,
  output logic [FI_W-1:0] frame_idx,
  output logic            frame_last,
  output logic            done,
  output logic            ovf
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW = $clog2(FRAME_LEN + 1);

  if (HOP < 1 || HOP > FRAME_LEN) begin : g_bad_hop
    $error("sample_framer: HOP must lie in 1..FRAME_LEN");
  end

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT, S_HOP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [I_BW-1:0] mem [FRAME_LEN];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            accept;

  // Circular pointer increment. FRAME_LEN need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FRAME_LEN - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    di_rdy  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FILL;
      S_FILL: begin
        di_rdy = 1'b1;
        if (di_en && cnt == CW'(FRAME_LEN - 1)) state_d = S_EMIT;
      end
      S_HOP: begin
        di_rdy = 1'b1;
        if (di_en && cnt == CW'(HOP - 1)) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (cnt == CW'(FRAME_LEN - 1))
          state_d = (frame_idx == FI_W'(NUM_FRAMES - 1)) ? S_DONE : S_HOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = di_en && di_rdy;
  assign done   = (state_q == S_DONE);

  // Sample storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      do_en      <= 1'b0;
      data_o     <= '0;
      frame_idx  <= '0;
      frame_last <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state_q    <= state_d;
      do_en      <= 1'b0;
      frame_last <= 1'b0;
      if (accept) wp <= ptr_inc(wp);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt       <= '0;
            frame_idx <= '0;
            ovf       <= 1'b0;
          end
        end
        S_FILL, S_HOP: begin
          if (accept) cnt <= (state_d == S_EMIT) ? '0 : cnt + CW'(1);
          // After the final write, the slot after it holds the oldest sample.
          if (state_d == S_EMIT) rp <= ptr_inc(wp);
        end
        S_EMIT: begin
          data_o     <= mem[rp];
          do_en      <= 1'b1;
          rp         <= ptr_inc(rp);
          frame_last <= (cnt == CW'(FRAME_LEN - 1));
          // Wrapping to zero on the last read also clears the hop count.
          cnt        <= (cnt == CW'(FRAME_LEN - 1)) ? '0 : cnt + CW'(1);
          if (di_en) ovf <= 1'b1;
        end
        default: ;
      endcase
      // Advance the index in the cycle after the last sample of a frame
      // leaves data_o, so frame_idx is stable across every emitted frame.
      if (do_en && frame_last && state_q == S_HOP) frame_idx <= frame_idx + FI_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;

  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        di_en = 1'b0;
  logic [13:0] data_i = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  // dut1: HOP=4, 3 frames. dut2: HOP=8, 2 frames. sel picks the one being driven.
  logic        start1, start2, en1, en2;
  logic        di_rdy1, do_en1, frame_last1, done1, ovf1;
  logic        di_rdy2, do_en2, frame_last2, done2, ovf2;
  logic [13:0] data_o1, data_o2;
  logic [1:0]  frame_idx1;
  logic [0:0]  frame_idx2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign en1    = di_en & ~sel;
  assign en2    = di_en & sel;

  sample_framer #(.I_BW(14), .FRAME_LEN(FL), .HOP(4), .NUM_FRAMES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .di_en(en1), .data_i(data_i),
    .di_rdy(di_rdy1), .do_en(do_en1), .data_o(data_o1), .frame_idx(frame_idx1),
    .frame_last(frame_last1), .done(done1), .ovf(ovf1));

  sample_framer #(.I_BW(14), .FRAME_LEN(FL), .HOP(8), .NUM_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .di_en(en2), .data_i(data_i),
    .di_rdy(di_rdy2), .do_en(do_en2), .data_o(data_o2), .frame_idx(frame_idx2),
    .frame_last(frame_last2), .done(done2), .ovf(ovf2));

  logic        rdy, en_o, last_m, done_m, ovf_m;
  logic [13:0] dat_m;
  logic [1:0]  fidx_m;

  assign rdy    = sel ? di_rdy2     : di_rdy1;
  assign en_o   = sel ? do_en2      : do_en1;
  assign dat_m  = sel ? data_o2     : data_o1;
  assign fidx_m = sel ? {1'b0, frame_idx2} : frame_idx1;
  assign last_m = sel ? frame_last2 : frame_last1;
  assign done_m = sel ? done2       : done1;
  assign ovf_m  = sel ? ovf2        : ovf1;

  // Reference model: the list of accepted samples; frame k, position j is
  // accepted sample number k*HOP + j.
  int acc_q[$];
  int out_cnt  = 0;
  int next_val = 1;
  int hop_m    = 4;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, then return 1ns after the edge.
  task automatic step(output bit acc);
    int k, j, idx;
    @(negedge clk);
    acc = (di_en && rdy);
    if (acc) acc_q.push_back(int'(data_i));
    if (en_o === 1'b1) begin
      k   = out_cnt / FL;
      j   = out_cnt % FL;
      idx = k * hop_m + j;
      check("frame_data", 32'(dat_m), (idx < acc_q.size()) ? acc_q[idx] : -1);
      check("frame_idx", 32'(fidx_m), k);
      check("frame_last", 32'(last_m), (j == FL - 1) ? 1 : 0);
      out_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  task automatic do_start();
    acc_q.delete();
    out_cnt  = 0;
    next_val = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Source that honours di_rdy; duty sets the chance of offering when ready.
  task automatic feed(input int n, input int duty);
    int got = 0;
    int cyc = 0;
    bit a;
    while (got < n && cyc < 400) begin
      di_en  = rdy && ($urandom_range(99) < duty);
      data_i = 14'(next_val);
      step(a);
      if (a) begin
        got++;
        next_val++;
      end
      cyc++;
    end
    di_en = 1'b0;
    check("feed_accepts", got, n);
  endtask

  task automatic wait_done(input int frames);
    int cyc = 0;
    while (done_m !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    tick();  // collect the final sample, which shares its cycle with done rising
    check("done", 32'(done_m), 1);
    check("out_count", out_cnt, frames * FL);
    check("idle_do_en", 32'(en_o), 0);
  endtask

  initial begin
    // Reset values
    #1 rst = 1'b0;
    #1;
    check("rst_di_rdy", 32'(rdy), 0);
    check("rst_do_en", 32'(en_o), 0);
    check("rst_frame_last", 32'(last_m), 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_ovf", 32'(ovf_m), 0);
    check("rst_data_o", 32'(dat_m), 0);
    check("rst_frame_idx", 32'(fidx_m), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: back-to-back stream, overlapping frames 1..8, 5..12, 9..16
    do_start();
    feed(16, 100);
    wait_done(3);
    check("t1_ovf", 32'(ovf_m), 0);
    check("t1_frame_idx_done", 32'(fidx_m), 2);

    // 2: EMIT latency and gap-free burst
    do_start();
    check("t2_done_cleared", 32'(done_m), 0);
    feed(8, 100);
    for (int i = 0; i <= 8; i++) begin
      check("t2_emit_do_en", 32'(en_o), (i >= 1) ? 1 : 0);
      if (i <= 7) check("t2_emit_di_rdy", 32'(rdy), 0);
      tick();
    end
    check("t2_burst_end", 32'(en_o), 0);
    feed(8, 100);
    wait_done(3);

    // 3: offers during EMIT are dropped and flagged
    do_start();
    check("t3_ovf_cleared", 32'(ovf_m), 0);
    feed(8, 100);
    for (int i = 0; i < 8; i++) begin
      di_en  = 1'b1;
      data_i = 14'(16'h3F00 + i);
      check("t3_emit_di_rdy", 32'(rdy), 0);
      tick();
    end
    di_en = 1'b0;
    check("t3_ovf_set", 32'(ovf_m), 1);
    feed(8, 100);
    wait_done(3);
    check("t3_ovf_sticky", 32'(ovf_m), 1);

    // 4: random gaps on the input stream
    do_start();
    feed(16, 50);
    wait_done(3);
    check("t4_ovf", 32'(ovf_m), 0);

    // 5: reset during the second frame's EMIT
    do_start();
    feed(12, 100);
    repeat (3) tick();
    check("t5_pre_rst_do_en", 32'(en_o), 1);
    rst = 1'b0;
    #1;
    check("t5_rst_do_en", 32'(en_o), 0);
    check("t5_rst_di_rdy", 32'(rdy), 0);
    check("t5_rst_frame_idx", 32'(fidx_m), 0);
    check("t5_rst_data_o", 32'(dat_m), 0);
    check("t5_rst_frame_last", 32'(last_m), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    feed(16, 100);
    wait_done(3);

    // 6: start ignored mid-run; start from DONE restarts cleanly
    do_start();
    feed(3, 100);
    start = 1'b1; tick(); start = 1'b0;  // FILL
    feed(5, 100);
    start = 1'b1; tick(); start = 1'b0;  // EMIT
    feed(2, 100);
    start = 1'b1; tick(); start = 1'b0;  // HOP
    feed(6, 100);
    wait_done(3);
    for (int i = 0; i < 3; i++) begin
      di_en  = 1'b1;
      data_i = 14'(16'h3E00 + i);
      check("t6_done_di_rdy", 32'(rdy), 0);
      tick();
    end
    di_en = 1'b0;
    check("t6_done_drop_no_ovf", 32'(ovf_m), 0);
    do_start();
    check("t6_restart_done", 32'(done_m), 0);
    check("t6_restart_frame_idx", 32'(fidx_m), 0);
    check("t6_restart_di_rdy", 32'(rdy), 1);
    feed(16, 100);
    wait_done(3);

    // HOP == FRAME_LEN: non-overlapping frames 1..8, 9..16
    sel   = 1'b1;
    hop_m = 8;
    #1;
    check("t6b_idle_di_rdy", 32'(rdy), 0);
    do_start();
    feed(16, 70);
    wait_done(2);
    check("t6b_ovf", 32'(ovf_m), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
